// File: rtl/calc_pkg.sv
// Shared key codes, state encoding and operator encoding for the calculator sequencer.
// Operator codes double as the ALU opcode.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_INITIAL   = 3'd0,
        ST_OPERAND_F = 3'd1,
        ST_OPERATION = 3'd2,
        ST_OPERAND_S = 3'd3,
        ST_RESULT    = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_EQUAL = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    function automatic op_e key_to_op(input logic [3:0] key);
        op_e op;
        case (key)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational unsigned ALU; results wrap modulo 2^WIDTH.
// A zero divisor passes operand a through and raises div_by_zero.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    always_comb begin
        result      = a;
        div_by_zero = 1'b0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = a * b;
            OP_DIV: begin
                if (b == '0) begin
                    div_by_zero = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            default: result = a;
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: edge-detects key presses, runs the entry FSM and
// holds both operands; arithmetic is delegated to calc_alu.
//
// state        | meaning
// INITIAL      | waiting for first digit
// OPERAND_F    | entering first operand
// OPERATION    | operator latched, waiting for second operand
// OPERAND_S    | entering second operand (display shows it)
// RESULT       | result in operand_f, '=' repeats last op
// ERROR        | division by zero, only clear accepted
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       button,
    input  logic             is_pressed_next,
    output logic [WIDTH-1:0] operand_f,
    output logic [WIDTH-1:0] operand_s,
    output logic             show_second,
    output logic             error,
    output logic [2:0]       state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] operand_f_q, operand_f_d;
    logic [WIDTH-1:0] operand_s_q, operand_s_d;
    logic [CW-1:0]    count_q, count_d;
    logic             prev_q;

    logic             press;
    logic [WIDTH-1:0] digit_val;
    logic [WIDTH-1:0] accum_f;
    logic [WIDTH-1:0] accum_s;
    logic [WIDTH-1:0] alu_result;
    logic             alu_div_zero;
    logic             can_accum;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a           (operand_f_q),
        .b           (operand_s_q),
        .op          (op_q),
        .result      (alu_result),
        .div_by_zero (alu_div_zero)
    );

    assign press     = is_pressed_next & ~prev_q;
    assign digit_val = {{(WIDTH-4){1'b0}}, button};
    assign accum_f   = operand_f_q * WIDTH'(10) + digit_val;
    assign accum_s   = operand_s_q * WIDTH'(10) + digit_val;
    assign can_accum = count_q < MAX_CNT;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        operand_f_d = operand_f_q;
        operand_s_d = operand_s_q;
        count_d     = count_q;

        if (press && button == KEY_CLEAR) begin
            state_d     = ST_INITIAL;
            op_d        = OP_ADD;
            operand_f_d = '0;
            operand_s_d = '0;
            count_d     = '0;
        end else begin
            case (state_q)
                ST_INITIAL: begin
                    if (press && is_digit(button)) begin
                        operand_f_d = digit_val;
                        count_d     = ONE_CNT;
                        state_d     = ST_OPERAND_F;
                    end
                end
                ST_OPERAND_F: begin
                    if (press && is_digit(button) && can_accum) begin
                        operand_f_d = accum_f;
                        count_d     = count_q + ONE_CNT;
                    end else if (press && is_operator(button)) begin
                        op_d    = key_to_op(button);
                        state_d = ST_OPERATION;
                    end
                end
                ST_OPERATION: begin
                    if (press && is_operator(button)) begin
                        op_d = key_to_op(button);
                    end else if (press && is_digit(button)) begin
                        operand_s_d = digit_val;
                        count_d     = ONE_CNT;
                        state_d     = ST_OPERAND_S;
                    end
                end
                ST_OPERAND_S: begin
                    if (press && is_digit(button)) begin
                        if (can_accum) begin
                            operand_s_d = accum_s;
                            count_d     = count_q + ONE_CNT;
                        end
                    end else if (press && alu_div_zero) begin
                        state_d = ST_ERROR;
                    end else if (press && button == KEY_EQUAL) begin
                        operand_f_d = alu_result;
                        state_d     = ST_RESULT;
                    end else if (press && is_operator(button)) begin
                        // Chaining: fold the pending op before latching the new one.
                        operand_f_d = alu_result;
                        operand_s_d = '0;
                        op_d        = key_to_op(button);
                        count_d     = '0;
                        state_d     = ST_OPERATION;
                    end
                end
                ST_RESULT: begin
                    if (press && button == KEY_EQUAL) begin
                        if (alu_div_zero) begin
                            state_d = ST_ERROR;
                        end else begin
                            operand_f_d = alu_result;
                        end
                    end else if (press && is_operator(button)) begin
                        op_d        = key_to_op(button);
                        operand_s_d = '0;
                        count_d     = '0;
                        state_d     = ST_OPERATION;
                    end else if (press && is_digit(button)) begin
                        operand_f_d = digit_val;
                        operand_s_d = '0;
                        count_d     = ONE_CNT;
                        state_d     = ST_OPERAND_F;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: state_d = ST_INITIAL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // Tracks the key level even in reset so a held key is not seen as a press on release.
        prev_q <= is_pressed_next;
        if (reset) begin
            state_q     <= ST_INITIAL;
            op_q        <= OP_ADD;
            operand_f_q <= '0;
            operand_s_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            operand_f_q <= operand_f_d;
            operand_s_q <= operand_s_d;
            count_q     <= count_d;
        end
    end

    assign operand_f   = operand_f_q;
    assign operand_s   = operand_s_q;
    assign show_second = (state_q == ST_OPERAND_S);
    assign error       = (state_q == ST_ERROR);
    assign state       = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer at WIDTH=8, MAX_DIGITS=3 with hand-computed results.
module tb_calc_sequencer;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       button;
    logic             is_pressed_next;
    logic [WIDTH-1:0] operand_f;
    logic [WIDTH-1:0] operand_s;
    logic             show_second;
    logic             error;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;

    calc_sequencer #(.WIDTH(WIDTH), .MAX_DIGITS(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .button          (button),
        .is_pressed_next (is_pressed_next),
        .operand_f       (operand_f),
        .operand_s       (operand_s),
        .show_second     (show_second),
        .error           (error),
        .state           (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clock);
        button          = k;
        is_pressed_next = 1'b1;
        @(negedge clock);
        is_pressed_next = 1'b0;
        @(negedge clock);
    endtask

    task automatic hold(input logic [3:0] k, input int cycles);
        @(negedge clock);
        button          = k;
        is_pressed_next = 1'b1;
        repeat (cycles) @(negedge clock);
        is_pressed_next = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset           = 1'b1;
        button          = 4'h0;
        is_pressed_next = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_f", operand_f, 0);
        check("rst_s", operand_s, 0);
        check("rst_state", state, 0);
        check("rst_err", error, 0);
        check("rst_show", show_second, 0);
        reset = 1'b0;

        // 12 + 34 =
        press(4'h1); press(4'h2);
        check("f12", operand_f, 12);
        check("f12_state", state, 1);
        press(4'hA); press(4'h3);
        check("ops_state", state, 3);
        check("ops_show", show_second, 1);
        press(4'h4);
        check("s34", operand_s, 34);
        press(4'hE);
        check("add_f", operand_f, 46);
        check("add_state", state, 4);
        check("add_show", show_second, 0);

        // 7 - 9 = wraps, then = repeats
        press(4'h7);
        check("res_digit_s", operand_s, 0);
        press(4'hB); press(4'h9); press(4'hE);
        check("sub_wrap", operand_f, 254);
        press(4'hE);
        check("sub_repeat", operand_f, 245);

        // 2 + 3 * 4 = chained left to right
        press(4'h2); press(4'hA); press(4'h3); press(4'hC);
        check("chain_mid_f", operand_f, 5);
        check("chain_mid_s", operand_s, 0);
        check("chain_mid_state", state, 2);
        press(4'h4); press(4'hE);
        check("chain_f", operand_f, 20);
        press(4'h5);
        check("res_digit_f", operand_f, 5);
        check("res_digit_state", state, 1);

        // operator replacement, then operator from RESULT
        press(4'hF); press(4'h9); press(4'hA); press(4'hB); press(4'h4); press(4'hE);
        check("op_replace", operand_f, 5);
        press(4'hC); press(4'h3); press(4'hE);
        check("res_op_mul", operand_f, 15);

        // 17 / 5 truncates
        press(4'hF); press(4'h1); press(4'h7); press(4'hD); press(4'h5); press(4'hE);
        check("div_trunc", operand_f, 3);

        // divide by zero
        press(4'hF); press(4'h8); press(4'hD); press(4'h0); press(4'hE);
        check("dz_err", error, 1);
        check("dz_state", state, 5);
        check("dz_f", operand_f, 8);
        press(4'h5);
        check("dz_ignore_f", operand_f, 8);
        check("dz_ignore_state", state, 5);
        press(4'hF);
        check("clr_f", operand_f, 0);
        check("clr_s", operand_s, 0);
        check("clr_state", state, 0);
        check("clr_err", error, 0);

        // digit limit
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("max_digits", operand_f, 123);

        // held key gives one digit
        press(4'hF); press(4'h1);
        hold(4'h5, 10);
        check("hold_once", operand_f, 15);

        // reset mid-entry with key held across release
        press(4'hF); press(4'h1); press(4'hA); press(4'h2);
        check("pre_rst_state", state, 3);
        @(negedge clock);
        reset           = 1'b1;
        button          = 4'h3;
        is_pressed_next = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("held_rst_f", operand_f, 0);
        check("held_rst_s", operand_s, 0);
        check("held_rst_state", state, 0);
        check("held_rst_show", show_second, 0);
        is_pressed_next = 1'b0;
        @(negedge clock);
        press(4'h4);
        check("after_rst_f", operand_f, 4);
        check("after_rst_state", state, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (min 8).
REQ-002 SHALL have parameter MAX_DIGITS, default 9, meaning maximum decimal digits accepted per operand.
REQ-003 SHALL have port clock  input  1  single clock, all state on positive edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port button  input  4  key code: 0-9 digit, A add, B sub, C mul, D div, E equal, F clear.
REQ-006 SHALL have port is_pressed_next  input  1  raw key-down level.
REQ-007 SHALL have port operand_f  output  WIDTH  first operand / accumulated result.
REQ-008 SHALL have port operand_s  output  WIDTH  second operand.
REQ-009 SHALL have port show_second  output  1  high when the display must show operand_s.
REQ-010 SHALL have port error  output  1  high while in ERROR state.
REQ-011 SHALL have port state  output  3  current FSM state code.

Function
REQ-012 SHALL detect a press as is_pressed_next=1 with registered previous level=0; one action per press; key held = no repeat.
REQ-013 SHALL act on a press at the same clock edge it is detected; outputs reflect it the following cycle (latency 1).
REQ-014 SHALL implement states INITIAL(0), OPERAND_F(1), OPERATION(2), OPERAND_S(3), RESULT(4), ERROR(5); codes 6-7 unused, recover to INITIAL.
REQ-015 INITIAL: digit d -> operand_f=d, digit count 1, go OPERAND_F; operator/equal ignored.
REQ-016 OPERAND_F: digit -> operand_f=operand_f*10+d if count<MAX_DIGITS, else ignored; operator -> latch op, go OPERATION; equal ignored.
REQ-017 OPERATION: operator -> replace latched op; digit d -> operand_s=d, count 1, go OPERAND_S; equal ignored.
REQ-018 OPERAND_S: digit -> operand_s accumulate with MAX_DIGITS limit; equal -> operand_f=operand_f op operand_s, go RESULT; operator -> compute as equal, latch new op, clear operand_s, go OPERATION (chaining).
REQ-019 RESULT: equal -> repeat last op with retained operand_s; operator -> latch op, clear operand_s, go OPERATION; digit d -> operand_f=d, operand_s=0, go OPERAND_F.
REQ-020 SHALL apply unsigned arithmetic truncated modulo 2^WIDTH for add, sub (wraps), mul, and digit accumulation.
REQ-021 SHALL use unsigned integer division, truncated toward zero.
REQ-022 Division with operand_s=0 SHALL leave operand_f unchanged and go ERROR with error=1.
REQ-023 ERROR SHALL ignore all keys except clear.
REQ-024 Clear from any state SHALL zero operand_f, operand_s, digit count, latched op (add), go INITIAL, in one cycle.
REQ-025 show_second SHALL be 1 exactly in OPERAND_S.

Reset
REQ-026 During reset: operand_f=0, operand_s=0, op=add, count=0, state=INITIAL, error=0, show_second=0.
REQ-027 The previous-level register SHALL load is_pressed_next during reset, so a key held across reset release is not a press.
REQ-028 Reset SHALL take priority over any simultaneous press; reset mid-entry discards all partial operands.

Structure
REQ-029 Shared package calc_pkg SHALL hold key-code constants, state encoding, and op encoding (add 0, sub 1, mul 2, div 3).
REQ-030 Arithmetic SHALL be a combinational sub-module calc_alu (WIDTH-parameterised; a, b, op -> result, div_by_zero); the FSM and operand registers stay in calc_sequencer.

Verification
REQ-031 Reset, press 1,2,+,3,4,= -> operand_f=46, state RESULT, show_second 0.
REQ-032 Press 7,-,9,= at WIDTH=8 -> operand_f=254 (wrap); then = again -> 245.
REQ-033 Press 2,+,3,*,4,= -> operand_f=20 (chaining left-to-right); press 5 then -> operand_f=5, state OPERAND_F.
REQ-034 Press 8,/,0,= -> error=1, state ERROR, operand_f=8; press 5 -> unchanged; press F -> all zero, INITIAL.
REQ-035 MAX_DIGITS=3, press 1,2,3,4 -> operand_f=123; hold key for 10 cycles -> only one digit accepted.
REQ-036 Assert reset while in OPERAND_S with key held, release -> all outputs zero, no press registered until key released and re-pressed.
